// File: rtl/prc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prc_pkg                                                          |
// | Brief   : Shared types and constants for the packet read engine.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package prc_pkg;

    localparam int PRC_STATE_W = 3;
    localparam int PKT_CNT_W   = 16;
    localparam int OVR_CNT_W   = 8;
    localparam int DLY_W       = 4;

    typedef enum logic [PRC_STATE_W-1:0] {
        IDLE_S  = 3'd0,
        FIRST_S = 3'd1,
        ACK_S   = 3'd2,
        WAIT_S  = 3'd3,
        REL_S   = 3'd4
    } prc_state_e;

    function automatic int prc_aw(input int bufid_w, input int line_w);
        return bufid_w + line_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prc_bufid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prc_bufid_fifo                                                   |
// | Brief   : Synchronous bufid cache FIFO with registered full and occupancy. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module prc_bufid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic [CW-1:0]    o_count,
    output logic             o_drop
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [PW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0]    r_count_q,  w_count_d;
    logic             r_full_q,   w_full_d;
    logic             w_push;
    logic             w_pop;

    // A push while full is lost even if a pop frees a slot in the same cycle.
    assign w_push = i_wr & ~r_full_q;
    assign w_pop  = i_rd & (r_count_q != '0);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + PW'(1);
        end
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count_q - CW'(1);
        end
        w_full_d = (w_count_d == CW'(DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_full_q   <= 1'b0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_full_q   <= w_full_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr_q] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rd_ptr_q];
    assign o_full  = r_full_q;
    assign o_count = r_count_q;
    assign o_drop  = i_wr & r_full_q;

endmodule
`default_nettype wire

// File: rtl/pkt_read_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pkt_read_engine                                                  |
// | Brief   : Per-port packet read controller: caches bufids, issues line      |
// |           reads with latency spacing, releases bufids to PCB.              |
// |           Define PRC_STAT_EN to enable released-packet/overrun counters.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pkt_read_engine
    import prc_pkg::*;
#(
    parameter int BUFID_W     = 9,
    parameter int LINE_W      = 7,
    parameter int CACHE_DEPTH = 4,
    parameter int RD_LATENCY  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [BUFID_W-1:0]        iv_pkt_bufid,
    input  logic                      i_pkt_bufid_wr,
    output logic                      o_pkt_bufid_ack,
    output logic                      o_cache_full,
    output logic [BUFID_W-1:0]        ov_pkt_bufid,
    output logic                      o_pkt_bufid_wr,
    input  logic                      i_pkt_bufid_ack,
    output logic [BUFID_W+LINE_W-1:0] ov_pkt_raddr,
    output logic                      o_pkt_rd,
    input  logic                      i_pkt_raddr_ack,
    input  logic                      i_pkt_rd_req,
    input  logic                      i_pkt_tx_finish,
    output logic                      o_err_pulse,
    output logic [2:0]                ov_prc_state,
    output logic [15:0]               ov_pkt_cnt,
    output logic [7:0]                ov_overrun_cnt
);

    localparam int                AW          = prc_aw(BUFID_W, LINE_W);
    localparam int                CW          = $clog2(CACHE_DEPTH) + 1;
    localparam logic [DLY_W-1:0]  c_DLY_LAT   = DLY_W'(RD_LATENCY);
    localparam logic [DLY_W-1:0]  c_DLY_MAX   = DLY_W'(RD_LATENCY + 2);
    localparam logic [LINE_W-1:0] c_LINE_LAST = '1;

    logic [BUFID_W-1:0] w_fifo_dout;
    logic [CW-1:0]      w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_drop;
    logic               w_pop;
    logic               w_cache_empty;

    prc_state_e         r_state_q,     w_state_d;
    logic [BUFID_W-1:0] r_bufid_q,     w_bufid_d;
    logic [AW-1:0]      r_raddr_q,     w_raddr_d;
    logic [LINE_W-1:0]  r_line_cnt_q,  w_line_cnt_d;
    logic [DLY_W-1:0]   r_dly_q,       w_dly_d;
    logic               r_fin_q,       w_fin_d;
    logic               r_rd_q,        w_rd_d;
    logic               r_rel_wr_q,    w_rel_wr_d;
    logic [BUFID_W-1:0] r_rel_bufid_q, w_rel_bufid_d;
    logic               r_ack_q,       w_ack_d;
    logic               r_err_q,       w_err_d;
    logic               w_go_rel;
    logic               w_rel_accept;
    logic               w_overrun;

    prc_bufid_fifo #(
        .DEPTH (CACHE_DEPTH),
        .WIDTH (BUFID_W),
        .CW    (CW)
    ) u_cache (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (i_pkt_bufid_wr),
        .i_din   (iv_pkt_bufid),
        .i_rd    (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count),
        .o_drop  (w_fifo_drop)
    );

    assign w_cache_empty = (w_fifo_count == '0);

    always_comb begin
        w_state_d     = r_state_q;
        w_bufid_d     = r_bufid_q;
        w_raddr_d     = r_raddr_q;
        w_line_cnt_d  = r_line_cnt_q;
        w_dly_d       = r_dly_q;
        w_fin_d       = r_fin_q;
        w_rd_d        = r_rd_q;
        w_rel_wr_d    = r_rel_wr_q;
        w_rel_bufid_d = r_rel_bufid_q;
        w_ack_d       = 1'b0;
        w_err_d       = w_fifo_drop;
        w_pop         = 1'b0;
        w_go_rel      = 1'b0;
        w_rel_accept  = 1'b0;
        w_overrun     = 1'b0;

        case (r_state_q)
            IDLE_S: begin
                if (!w_cache_empty) begin
                    w_pop        = 1'b1;
                    w_bufid_d    = w_fifo_dout;
                    w_raddr_d    = {w_fifo_dout, {LINE_W{1'b0}}};
                    w_line_cnt_d = '0;
                    w_fin_d      = 1'b0;
                    w_ack_d      = 1'b1;
                    w_state_d    = FIRST_S;
                end
            end
            FIRST_S: begin
                if (i_pkt_tx_finish) begin
                    w_go_rel = 1'b1;
                end else if (i_pkt_rd_req) begin
                    w_rd_d    = 1'b1;
                    w_state_d = ACK_S;
                end
            end
            ACK_S: begin
                if (i_pkt_tx_finish) begin
                    w_fin_d = 1'b1;
                end
                if (i_pkt_raddr_ack) begin
                    w_rd_d    = 1'b0;
                    w_dly_d   = '0;
                    w_state_d = WAIT_S;
                end
            end
            WAIT_S: begin
                if (r_dly_q != c_DLY_MAX) begin
                    w_dly_d = r_dly_q + DLY_W'(1);
                end
                // An early finish is remembered so it is not lost before the data returns.
                if (i_pkt_tx_finish) begin
                    w_fin_d = 1'b1;
                end
                if ((r_dly_q >= c_DLY_LAT) && (r_fin_q || i_pkt_tx_finish)) begin
                    w_go_rel = 1'b1;
                end else if ((r_dly_q == c_DLY_MAX) && i_pkt_rd_req) begin
                    if (r_line_cnt_q == c_LINE_LAST) begin
                        w_overrun = 1'b1;
                        w_err_d   = 1'b1;
                        w_go_rel  = 1'b1;
                    end else begin
                        w_raddr_d    = r_raddr_q + AW'(1);
                        w_line_cnt_d = r_line_cnt_q + LINE_W'(1);
                        w_rd_d       = 1'b1;
                        w_state_d    = ACK_S;
                    end
                end
            end
            REL_S: begin
                if (i_pkt_bufid_ack) begin
                    w_rel_wr_d   = 1'b0;
                    w_fin_d      = 1'b0;
                    w_rel_accept = 1'b1;
                    w_state_d    = IDLE_S;
                end
            end
            default: begin
                w_state_d  = IDLE_S;
                w_rd_d     = 1'b0;
                w_rel_wr_d = 1'b0;
                w_fin_d    = 1'b0;
            end
        endcase

        if (w_go_rel) begin
            w_state_d     = REL_S;
            w_rd_d        = 1'b0;
            w_rel_wr_d    = 1'b1;
            w_rel_bufid_d = r_bufid_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q     <= IDLE_S;
            r_bufid_q     <= '0;
            r_raddr_q     <= '0;
            r_line_cnt_q  <= '0;
            r_dly_q       <= '0;
            r_fin_q       <= 1'b0;
            r_rd_q        <= 1'b0;
            r_rel_wr_q    <= 1'b0;
            r_rel_bufid_q <= '0;
            r_ack_q       <= 1'b0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_bufid_q     <= w_bufid_d;
            r_raddr_q     <= w_raddr_d;
            r_line_cnt_q  <= w_line_cnt_d;
            r_dly_q       <= w_dly_d;
            r_fin_q       <= w_fin_d;
            r_rd_q        <= w_rd_d;
            r_rel_wr_q    <= w_rel_wr_d;
            r_rel_bufid_q <= w_rel_bufid_d;
            r_ack_q       <= w_ack_d;
            r_err_q       <= w_err_d;
        end
    end

    assign o_pkt_bufid_ack = r_ack_q;
    assign o_cache_full    = w_fifo_full;
    assign ov_pkt_bufid    = r_rel_bufid_q;
    assign o_pkt_bufid_wr  = r_rel_wr_q;
    assign ov_pkt_raddr    = r_raddr_q;
    assign o_pkt_rd        = r_rd_q;
    assign o_err_pulse     = r_err_q;
    assign ov_prc_state    = r_state_q;

`ifdef PRC_STAT_EN
    logic [PKT_CNT_W-1:0] r_pkt_cnt_q, w_pkt_cnt_d;
    logic [OVR_CNT_W-1:0] r_ovr_cnt_q, w_ovr_cnt_d;

    always_comb begin
        w_pkt_cnt_d = r_pkt_cnt_q;
        w_ovr_cnt_d = r_ovr_cnt_q;
        if (w_rel_accept) begin
            w_pkt_cnt_d = r_pkt_cnt_q + PKT_CNT_W'(1);
        end
        if (w_overrun && (r_ovr_cnt_q != '1)) begin
            w_ovr_cnt_d = r_ovr_cnt_q + OVR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt_cnt_q <= '0;
            r_ovr_cnt_q <= '0;
        end else begin
            r_pkt_cnt_q <= w_pkt_cnt_d;
            r_ovr_cnt_q <= w_ovr_cnt_d;
        end
    end

    assign ov_pkt_cnt     = r_pkt_cnt_q;
    assign ov_overrun_cnt = r_ovr_cnt_q;
`else
    logic w_stat_unused;
    assign w_stat_unused  = w_rel_accept | w_overrun;
    assign ov_pkt_cnt     = '0;
    assign ov_overrun_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_read_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pkt_read_engine                                               |
// | Brief   : Directed self-checking bench for pkt_read_engine (two configs).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pkt_read_engine;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic [8:0]  r_bufid;
    logic        r_bufid_wr, r_rel_ack, r_raddr_ack, r_rd_req, r_fin;
    logic        w_ack, w_full, w_rel_wr, w_rd, w_err;
    logic [8:0]  w_rel_bufid;
    logic [15:0] w_raddr;
    logic [2:0]  w_state;
    logic [15:0] w_pkt_cnt;
    logic [7:0]  w_ovr_cnt;

    logic [8:0]  r_bufid2;
    logic        r_bufid_wr2, r_rel_ack2, r_raddr_ack2, r_rd_req2, r_fin2;
    logic        w_ack2, w_full2, w_rel_wr2, w_rd2, w_err2;
    logic [8:0]  w_rel_bufid2;
    logic [10:0] w_raddr2;
    logic [2:0]  w_state2;
    logic [15:0] w_pkt_cnt2;
    logic [7:0]  w_ovr_cnt2;

    pkt_read_engine u_dut (
        .i_clk(clk), .i_rst(rst),
        .iv_pkt_bufid(r_bufid), .i_pkt_bufid_wr(r_bufid_wr),
        .o_pkt_bufid_ack(w_ack), .o_cache_full(w_full),
        .ov_pkt_bufid(w_rel_bufid), .o_pkt_bufid_wr(w_rel_wr), .i_pkt_bufid_ack(r_rel_ack),
        .ov_pkt_raddr(w_raddr), .o_pkt_rd(w_rd), .i_pkt_raddr_ack(r_raddr_ack),
        .i_pkt_rd_req(r_rd_req), .i_pkt_tx_finish(r_fin),
        .o_err_pulse(w_err), .ov_prc_state(w_state),
        .ov_pkt_cnt(w_pkt_cnt), .ov_overrun_cnt(w_ovr_cnt)
    );

    pkt_read_engine #(.LINE_W(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst),
        .iv_pkt_bufid(r_bufid2), .i_pkt_bufid_wr(r_bufid_wr2),
        .o_pkt_bufid_ack(w_ack2), .o_cache_full(w_full2),
        .ov_pkt_bufid(w_rel_bufid2), .o_pkt_bufid_wr(w_rel_wr2), .i_pkt_bufid_ack(r_rel_ack2),
        .ov_pkt_raddr(w_raddr2), .o_pkt_rd(w_rd2), .i_pkt_raddr_ack(r_raddr_ack2),
        .i_pkt_rd_req(r_rd_req2), .i_pkt_tx_finish(r_fin2),
        .o_err_pulse(w_err2), .ov_prc_state(w_state2),
        .ov_pkt_cnt(w_pkt_cnt2), .ov_overrun_cnt(w_ovr_cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        r_bufid = '0; r_bufid_wr = 0; r_rel_ack = 0; r_raddr_ack = 0; r_rd_req = 0; r_fin = 0;
        r_bufid2 = '0; r_bufid_wr2 = 0; r_rel_ack2 = 0; r_raddr_ack2 = 0; r_rd_req2 = 0; r_fin2 = 0;
        repeat (3) tick();
        checks++;
        if ({w_ack, w_full, w_rel_wr, w_rd, w_err, w_state} !== 8'h00) begin
            errors++; $display("FAIL reset_ctl got %b exp 0", {w_ack, w_full, w_rel_wr, w_rd, w_err, w_state});
        end
        checks++;
        if ({w_raddr, w_rel_bufid, w_pkt_cnt, w_ovr_cnt} !== 49'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h exp 0", w_raddr, w_rel_bufid, w_pkt_cnt, w_ovr_cnt);
        end
        checks++;
        if ({w_ack2, w_full2, w_rel_wr2, w_rd2, w_err2, w_state2, w_raddr2} !== 19'h0) begin
            errors++; $display("FAIL reset_dut2 got %h exp 0", {w_ack2, w_full2, w_rel_wr2, w_rd2, w_err2, w_state2, w_raddr2});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_line;
        int n;
        r_bufid = 9'h005; r_bufid_wr = 1; r_rd_req = 1;
        tick();
        r_bufid_wr = 0;
        tick();
        checks++;
        if ({w_ack, w_state} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL t1_ack got ack=%b st=%0d exp ack=1 st=1", w_ack, w_state);
        end
        checks++;
        if (w_raddr !== 16'h0280) begin
            errors++; $display("FAIL t1_raddr got %h exp 0280", w_raddr);
        end
        tick();
        checks++;
        if ({w_rd, w_ack, w_state} !== {1'b1, 1'b0, 3'd2}) begin
            errors++; $display("FAIL t1_rd got rd=%b ack=%b st=%0d exp 1 0 2", w_rd, w_ack, w_state);
        end
        tick(); tick();
        checks++;
        if (w_rd !== 1'b1) begin
            errors++; $display("FAIL t1_rd_hold got %b exp 1", w_rd);
        end
        r_raddr_ack = 1; tick(); r_raddr_ack = 0;
        checks++;
        if ({w_rd, w_state} !== {1'b0, 3'd3}) begin
            errors++; $display("FAIL t1_rd_drop got rd=%b st=%0d exp 0 3", w_rd, w_state);
        end
        r_rd_req = 0; r_fin = 1;
        n = 0;
        while (w_rel_wr !== 1'b1 && n < 12) begin tick(); n++; end
        r_fin = 0;
        checks++;
        if ({w_rel_wr, w_rel_bufid, w_state} !== {1'b1, 9'h005, 3'd4}) begin
            errors++; $display("FAIL t1_release got wr=%b id=%h st=%0d exp 1 005 4", w_rel_wr, w_rel_bufid, w_state);
        end
        tick(); tick();
        checks++;
        if (w_rel_wr !== 1'b1) begin
            errors++; $display("FAIL t1_rel_hold got %b exp 1", w_rel_wr);
        end
        r_rel_ack = 1; tick(); r_rel_ack = 0;
        checks++;
        if ({w_rel_wr, w_state} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL t1_rel_done got wr=%b st=%0d exp 0 0", w_rel_wr, w_state);
        end
    endtask

    task automatic test_multi_line;
        int n;
        int ack_cyc;
        logic [15:0] exp_addr;
        ack_cyc = 0;
        r_bufid = 9'h005; r_bufid_wr = 1; r_rd_req = 1;
        tick();
        r_bufid_wr = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (w_rd !== 1'b1 && n < 20) begin tick(); n++; end
            checks++;
            if (w_rd !== 1'b1) begin
                errors++; $display("FAIL t2_rd_timeout line %0d got %b exp 1", k, w_rd);
            end
            if (k > 0) begin
                checks++;
                if ((cyc - ack_cyc) < 5) begin
                    errors++; $display("FAIL t2_gap line %0d got %0d exp >=5", k, cyc - ack_cyc);
                end
            end
            exp_addr = 16'h0280 + 16'(k);
            checks++;
            if (w_raddr !== exp_addr) begin
                errors++; $display("FAIL t2_raddr line %0d got %h exp %h", k, w_raddr, exp_addr);
            end
            r_raddr_ack = 1; tick(); ack_cyc = cyc; r_raddr_ack = 0;
        end
        r_rd_req = 0; r_fin = 1;
        n = 0;
        while (w_rel_wr !== 1'b1 && n < 12) begin tick(); n++; end
        r_fin = 0;
        checks++;
        if ({w_rel_wr, w_rel_bufid} !== {1'b1, 9'h005}) begin
            errors++; $display("FAIL t2_release got wr=%b id=%h exp 1 005", w_rel_wr, w_rel_bufid);
        end
        r_rel_ack = 1; tick(); r_rel_ack = 0;
    endtask

    task automatic test_cache_overflow;
        r_bufid = 9'h00A; r_bufid_wr = 1;
        tick();
        r_bufid_wr = 0;
        tick();
        checks++;
        if (w_state !== 3'd1) begin
            errors++; $display("FAIL t3_busy got st=%0d exp 1", w_state);
        end
        for (int k = 1; k <= 5; k++) begin
            r_bufid = 9'(k); r_bufid_wr = 1;
            tick();
            if (k == 4) begin
                checks++;
                if ({w_full, w_err} !== 2'b10) begin
                    errors++; $display("FAIL t3_full got full=%b err=%b exp 1 0", w_full, w_err);
                end
            end
            if (k == 5) begin
                checks++;
                if (w_err !== 1'b1) begin
                    errors++; $display("FAIL t3_drop_err got %b exp 1", w_err);
                end
            end
        end
        r_bufid_wr = 0;
        tick();
        checks++;
        if ({w_err, w_full} !== 2'b01) begin
            errors++; $display("FAIL t3_err_pulse got err=%b full=%b exp 0 1", w_err, w_full);
        end
        r_fin = 1; tick(); r_fin = 0;
        checks++;
        if ({w_state, w_rel_bufid} !== {3'd4, 9'h00A}) begin
            errors++; $display("FAIL t3_rel got st=%0d id=%h exp 4 00a", w_state, w_rel_bufid);
        end
    endtask

    task automatic test_release_hold;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (w_rel_wr !== 1'b1 || w_ack !== 1'b0 || w_state !== 3'd4) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL t4_hold got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (w_full !== 1'b1) begin
            errors++; $display("FAIL t4_no_pop got full=%b exp 1", w_full);
        end
        r_rel_ack = 1; tick(); r_rel_ack = 0;
        checks++;
        if (w_rel_wr !== 1'b0) begin
            errors++; $display("FAIL t4_accept got wr=%b exp 0", w_rel_wr);
        end
    endtask

    task automatic test_cache_order;
        int n;
        int bad;
        logic [15:0] exp_addr;
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (w_ack !== 1'b1 && n < 10) begin tick(); n++; end
            exp_addr = 16'(k) << 7;
            checks++;
            if ({w_ack, w_raddr} !== {1'b1, exp_addr}) begin
                errors++; $display("FAIL t3_order pop %0d got ack=%b addr=%h exp 1 %h", k, w_ack, w_raddr, exp_addr);
            end
            if (k == 1) begin
                checks++;
                if (w_full !== 1'b0) begin
                    errors++; $display("FAIL t3_unfull got %b exp 0", w_full);
                end
            end
            r_fin = 1; tick(); r_fin = 0;
            checks++;
            if ({w_rel_wr, w_rel_bufid} !== {1'b1, 9'(k)}) begin
                errors++; $display("FAIL t3_order_rel %0d got wr=%b id=%h exp 1 %h", k, w_rel_wr, w_rel_bufid, 9'(k));
            end
            r_rel_ack = 1; tick(); r_rel_ack = 0;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (w_ack !== 1'b0 || w_state !== 3'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL t3_fifth_dropped got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_overrun;
        int n;
        logic [10:0] exp_addr;
        logic [7:0]  exp_ovr;
        logic [15:0] exp_pkt;
`ifdef PRC_STAT_EN
        exp_ovr = 8'd1; exp_pkt = 16'd1;
`else
        exp_ovr = 8'd0; exp_pkt = 16'd0;
`endif
        r_bufid2 = 9'h003; r_bufid_wr2 = 1; r_rd_req2 = 1;
        tick();
        r_bufid_wr2 = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (w_rd2 !== 1'b1 && n < 20) begin tick(); n++; end
            exp_addr = 11'h00C + 11'(k);
            checks++;
            if ({w_rd2, w_raddr2} !== {1'b1, exp_addr}) begin
                errors++; $display("FAIL t5_read %0d got rd=%b addr=%h exp 1 %h", k, w_rd2, w_raddr2, exp_addr);
            end
            r_raddr_ack2 = 1; tick(); r_raddr_ack2 = 0;
        end
        n = 0;
        while (w_state2 !== 3'd4 && w_rd2 !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if ({w_state2, w_err2, w_rd2} !== {3'd4, 1'b1, 1'b0}) begin
            errors++; $display("FAIL t5_overrun got st=%0d err=%b rd=%b exp 4 1 0", w_state2, w_err2, w_rd2);
        end
        checks++;
        if ({w_rel_wr2, w_rel_bufid2} !== {1'b1, 9'h003}) begin
            errors++; $display("FAIL t5_release got wr=%b id=%h exp 1 003", w_rel_wr2, w_rel_bufid2);
        end
        checks++;
        if (w_ovr_cnt2 !== exp_ovr) begin
            errors++; $display("FAIL t5_ovr_cnt got %0d exp %0d", w_ovr_cnt2, exp_ovr);
        end
        r_rd_req2 = 0;
        tick();
        checks++;
        if (w_err2 !== 1'b0) begin
            errors++; $display("FAIL t5_err_pulse got %b exp 0", w_err2);
        end
        r_rel_ack2 = 1; tick(); r_rel_ack2 = 0;
        checks++;
        if ({w_rel_wr2, w_pkt_cnt2} !== {1'b0, exp_pkt}) begin
            errors++; $display("FAIL t5_pkt_cnt got wr=%b cnt=%0d exp 0 %0d", w_rel_wr2, w_pkt_cnt2, exp_pkt);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int bad;
        r_bufid = 9'h011; r_bufid_wr = 1; tick();
        r_bufid = 9'h012; tick();
        r_bufid_wr = 0; r_rd_req = 1;
        n = 0;
        while (w_rd !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if ({w_rd, w_state} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL t6_in_ack got rd=%b st=%0d exp 1 2", w_rd, w_state);
        end
        rst = 1; tick(); rst = 0; r_rd_req = 0;
        checks++;
        if ({w_rd, w_state, w_full, w_pkt_cnt} !== {1'b0, 3'd0, 1'b0, 16'd0}) begin
            errors++; $display("FAIL t6_reset got rd=%b st=%0d full=%b cnt=%0d exp 0 0 0 0", w_rd, w_state, w_full, w_pkt_cnt);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (w_rel_wr !== 1'b0 || w_ack !== 1'b0 || w_state !== 3'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL t6_quiet got %0d bad cycles exp 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_multi_line();
        test_cache_overflow();
        test_release_hold();
        test_cache_order();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
